imem_arbiter: RTL and testbench

- Shares the single-port instruction memory (512 x 32, synchronous read, 1-cycle read latency, plus a write port) between two requesters: the core fetch stage and the debug/program-load port.
- Grants one access per cycle. Returns read data one cycle after grant, tagged to the owning requester.
- Fetch has priority. The debug port is protected from starvation by a wait counter. The debug port can halt fetch for program loading.

---
 rtl/imem_arbiter_pkg.sv | 18 +
 rtl/imem_arbiter_if.sv | 38 +++
 rtl/imem_starve_cnt.sv | 34 +++
 rtl/imem_arbiter.sv | 74 +++++++
 tb/tb_imem_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_arbiter_pkg.sv
// Shared instruction-memory types and arbiter defaults.
// Single-cycle read memory, 512 words of 32 bits.
package imem_arbiter_pkg;
    localparam int MEM_SIZE = 512;
    localparam int ADDR_W   = $clog2(MEM_SIZE);

    typedef logic [ADDR_W-1:0] address_t;
    typedef logic [31:0]       word_t;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DBG   = 2'd2
    } owner_t;

    localparam int IMEM_STARVE_LIMIT_DEFAULT = 4;
    localparam int IMEM_CNT_W_DEFAULT        = 3;
endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, debug and memory-side signals of the instruction-memory arbiter.
// slave = arbiter view, master = requester/memory environment view.
interface imem_arbiter_if;
    import imem_arbiter_pkg::*;

    logic     f_req;
    address_t f_addr;
    logic     f_gnt;
    logic     f_rvalid;
    word_t    f_rdata;

    logic     d_req;
    logic     d_we;
    address_t d_addr;
    word_t    d_wdata;
    logic     d_halt;
    logic     d_gnt;
    logic     d_rvalid;
    word_t    d_rdata;

    logic     m_en;
    logic     m_we;
    address_t m_addr;
    word_t    m_wdata;
    word_t    m_rdata;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_halt, m_rdata,
        output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
               m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_halt, m_rdata,
        input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
               m_en, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/imem_starve_cnt.sv
// Saturating wait counter for a pending, denied request; clears on grant or idle.
// at_limit_o is registered state, so it reflects denials up to the previous cycle.
module imem_starve_cnt #(
    parameter int LIMIT = 4,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic req_i,
    input  logic gnt_i,
    output logic at_limit_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign at_limit_o = (cnt_q == CNT_W'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (!req_i || gnt_i) begin
            cnt_d = '0;
        end else if (!at_limit_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/imem_arbiter.sv
// Shares one instruction memory between fetch (priority) and debug; one grant per cycle.
// Grant is combinational, response returns one cycle later tagged by resp_own_q.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = IMEM_STARVE_LIMIT_DEFAULT,
    parameter int CNT_W        = IMEM_CNT_W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    imem_arbiter_if.slave  bus
);
    owner_t resp_own_q;
    owner_t resp_own_d;
    logic   starve_hit;
    logic   f_gnt;
    logic   d_gnt;

    imem_starve_cnt #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (CNT_W)
    ) u_starve_cnt (
        .clk        (clk),
        .rst        (rst),
        .req_i      (bus.d_req),
        .gnt_i      (d_gnt),
        .at_limit_o (starve_hit)
    );

    // Debug wins when starved, when it has halted fetch, or when fetch is idle.
    always_comb begin
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (bus.d_req && (starve_hit || bus.d_halt || !bus.f_req)) begin
                d_gnt = 1'b1;
            end else if (bus.f_req && !bus.d_halt) begin
                f_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        bus.m_en    = f_gnt | d_gnt;
        bus.m_we    = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        resp_own_d  = OWN_NONE;
        if (d_gnt) begin
            bus.m_we    = bus.d_we;
            bus.m_addr  = bus.d_addr;
            bus.m_wdata = bus.d_wdata;
            resp_own_d  = OWN_DBG;
        end else if (f_gnt) begin
            bus.m_addr  = bus.f_addr;
            resp_own_d  = OWN_FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_own_q <= OWN_NONE;
        end else begin
            resp_own_q <= resp_own_d;
        end
    end

    assign bus.f_gnt    = f_gnt;
    assign bus.d_gnt    = d_gnt;
    assign bus.f_rvalid = (resp_own_q == OWN_FETCH);
    assign bus.d_rvalid = (resp_own_q == OWN_DBG);
    assign bus.f_rdata  = bus.m_rdata;
    assign bus.d_rdata  = bus.m_rdata;
endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a memory model and a rule-level reference model.
module tb_imem_arbiter;
    import imem_arbiter_pkg::*;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    imem_arbiter_if bus ();

    imem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory attached to the arbiter
    word_t mem [MEM_SIZE];
    always @(posedge clk) begin
        if (bus.m_en) begin
            if (bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
            else          bus.m_rdata <= mem[bus.m_addr];
        end
    end

    // Reference model state
    word_t mdl_mem [MEM_SIZE];
    int    mdl_wait = 0;        // consecutive denied cycles of a pending debug request
    int    mdl_pend = 0;        // 0 none, 1 fetch response due, 2 debug response due
    int    mdl_pend_addr = 0;
    bit    mdl_pend_we = 1'b0;
    bit    e_fg, e_dg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        e_fg = 1'b0;
        e_dg = 1'b0;
        if (!rst) begin
            if (bus.d_req && (mdl_wait >= LIMIT || bus.d_halt || !bus.f_req)) e_dg = 1'b1;
            else if (bus.f_req && !bus.d_halt) e_fg = 1'b1;
        end
        chk("f_gnt", 32'(bus.f_gnt), 32'(e_fg));
        chk("d_gnt", 32'(bus.d_gnt), 32'(e_dg));
        chk("m_en", 32'(bus.m_en), 32'(e_fg | e_dg));
        chk("m_we", 32'(bus.m_we), 32'(e_dg & bus.d_we));
        chk("m_addr", 32'(bus.m_addr), e_dg ? 32'(bus.d_addr) : (e_fg ? 32'(bus.f_addr) : 32'd0));
        chk("m_wdata", bus.m_wdata, e_dg ? bus.d_wdata : 32'd0);
        chk("f_rvalid", 32'(bus.f_rvalid), 32'(mdl_pend == 1));
        chk("d_rvalid", 32'(bus.d_rvalid), 32'(mdl_pend == 2));
        if (mdl_pend == 1) chk("f_rdata", bus.f_rdata, mdl_mem[mdl_pend_addr]);
        if (mdl_pend == 2 && !mdl_pend_we) chk("d_rdata", bus.d_rdata, mdl_mem[mdl_pend_addr]);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_wait = 0;
            mdl_pend = 0;
        end else begin
            mdl_pend = e_dg ? 2 : (e_fg ? 1 : 0);
            if (e_dg) begin
                mdl_pend_addr = int'(bus.d_addr);
                mdl_pend_we   = bus.d_we;
                if (bus.d_we) mdl_mem[bus.d_addr] = bus.d_wdata;
            end else if (e_fg) begin
                mdl_pend_addr = int'(bus.f_addr);
                mdl_pend_we   = 1'b0;
            end
            if (!bus.d_req || e_dg) mdl_wait = 0;
            else if (mdl_wait < LIMIT) mdl_wait = mdl_wait + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < MEM_SIZE; i++) begin
            mem[i]     = 32'hA500_0000 | i;
            mdl_mem[i] = 32'hA500_0000 | i;
        end
        mem[9'h010] = 32'h0050_0093; mdl_mem[9'h010] = 32'h0050_0093;
        mem[9'h1FF] = 32'h1234_5678; mdl_mem[9'h1FF] = 32'h1234_5678;

        bus.f_req = 0; bus.f_addr = '0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.d_halt = 0; bus.m_rdata = '0;

        // Reset state
        @(negedge clk);
        chk("rst_m_en", 32'(bus.m_en), 32'd0);
        chk("rst_f_rvalid", 32'(bus.f_rvalid), 32'd0);
        chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        step();
        rst = 1'b0;

        // Fetch only
        bus.f_req = 1; bus.f_addr = 9'h010;
        @(negedge clk);
        chk("fo_gnt", 32'(bus.f_gnt), 32'd1);
        step();
        bus.f_req = 0;
        @(negedge clk);
        chk("fo_rvalid", 32'(bus.f_rvalid), 32'd1);
        chk("fo_rdata", bus.f_rdata, 32'h0050_0093);
        chk("fo_d_rvalid", 32'(bus.d_rvalid), 32'd0);
        step();

        // Contention: debug wins every fifth cycle
        bus.f_req = 1; bus.f_addr = 9'h010;
        bus.d_req = 1; bus.d_we = 0; bus.d_addr = 9'h1FF;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("ct_d_gnt%0d", c), 32'(bus.d_gnt), 32'((c % 5) == 4));
            chk($sformatf("ct_f_gnt%0d", c), 32'(bus.f_gnt), 32'((c % 5) != 4));
            if (c == 5) begin
                chk("ct_d_rvalid5", 32'(bus.d_rvalid), 32'd1);
                chk("ct_d_rdata5", bus.d_rdata, 32'h1234_5678);
            end
            step();
        end
        bus.f_req = 0; bus.d_req = 0;
        step();

        // Halt and load
        bus.d_halt = 1; bus.f_req = 1; bus.f_addr = 9'h030;
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 9'h020; bus.d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("hl_wr_gnt", 32'(bus.d_gnt), 32'd1);
        chk("hl_wr_we", 32'(bus.m_we), 32'd1);
        step();
        bus.d_we = 0;
        @(negedge clk);
        chk("hl_ack", 32'(bus.d_rvalid), 32'd1);
        chk("hl_rd_f_gnt", 32'(bus.f_gnt), 32'd0);
        step();
        bus.d_req = 0;
        @(negedge clk);
        chk("hl_rvalid", 32'(bus.d_rvalid), 32'd1);
        chk("hl_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        chk("hl_f_gnt", 32'(bus.f_gnt), 32'd0);
        step();
        bus.d_halt = 0; bus.f_req = 0;
        step();

        // Halt mid-stream
        for (int c = 0; c < 6; c++) begin
            bus.f_req = 1; bus.f_addr = address_t'(9'h040 + c); bus.d_halt = (c >= 3);
            @(negedge clk);
            chk($sformatf("hm_f_gnt%0d", c), 32'(bus.f_gnt), 32'(c < 3));
            if (c == 3) begin
                chk("hm_rvalid3", 32'(bus.f_rvalid), 32'd1);
                chk("hm_rdata3", bus.f_rdata, 32'hA500_0042);
            end
            if (c == 4) chk("hm_rvalid4", 32'(bus.f_rvalid), 32'd0);
            step();
        end
        bus.f_req = 0; bus.d_halt = 0;
        step();

        // Async reset mid-access with a partly advanced starve count
        bus.f_req = 1; bus.f_addr = 9'h011; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 9'h1FF;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("ar_f_gnt", 32'(bus.f_gnt), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("ar_f_rvalid_now", 32'(bus.f_rvalid), 32'd0);
        chk("ar_d_rvalid_now", 32'(bus.d_rvalid), 32'd0);
        @(negedge clk);
        chk("ar_f_gnt_rst", 32'(bus.f_gnt), 32'd0);
        chk("ar_m_en_rst", 32'(bus.m_en), 32'd0);
        step();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) chk("ar_no_pulse", 32'(bus.f_rvalid), 32'd0);
            chk($sformatf("ar_d_gnt%0d", c), 32'(bus.d_gnt), 32'(c == 4));
            step();
        end
        bus.f_req = 0; bus.d_req = 0;
        step();

        // Idle
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("id_m_en", 32'(bus.m_en), 32'd0);
            chk("id_m_addr", 32'(bus.m_addr), 32'd0);
            chk("id_rvalid", 32'(bus.f_rvalid | bus.d_rvalid), 32'd0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
